// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: round-robin merge of ALU and load writebacks onto
// one registered write port, plus a pending-write scoreboard for hazard queries.
module rf_write_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            sb_any_busy
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e          last_grant;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            xfer_a;
    logic            xfer_b;
    logic            xfer;
    logic [4:0]      xfer_rd;
    logic [XLEN-1:0] xfer_data;

    // Readies are pure functions of the valids and last_grant; reset masks both.
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                a_ready = (last_grant == GRANT_B);
                b_ready = (last_grant == GRANT_A);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign xfer_a    = a_valid && a_ready;
    assign xfer_b    = b_valid && b_ready;
    assign xfer      = xfer_a || xfer_b;
    assign xfer_rd   = xfer_b ? b_rd : a_rd;
    assign xfer_data = xfer_b ? b_data : a_data;

    // Clear for the committing write is applied first so a same-edge issue to that register wins.
    always_comb begin
        sb_next = sb;
        if (rf_we) begin
            sb_next[rf_waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            sb_next[iss_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            last_grant <= GRANT_B;
            // NOTE: the scoreboard is a flop array, not a RAM, and must start all-clear after reset.
            sb         <= '0;
        end else begin
            rf_we <= xfer && (xfer_rd != 5'd0);
            if (xfer) begin
                last_grant <= xfer_b ? GRANT_B : GRANT_A;
            end
            if (xfer && (xfer_rd != 5'd0)) begin
                rf_waddr <= xfer_rd;
                rf_wdata <= xfer_data;
            end
            sb <= sb_next;
        end
    end

    // No bypass: a register stays busy through its own write cycle.
    assign rs1_busy    = (rs1_addr != 5'd0) && sb[rs1_addr];
    assign rs2_busy    = (rs2_addr != 5'd0) && sb[rs2_addr];
    assign sb_any_busy = |sb[NREG-1:1];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter against a cycle-level
// reference model built from the arbitration and scoreboard rules.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1_addr, rs2_addr;
    logic [31:0] a_data, b_data;
    logic        rs1_busy, rs2_busy, rf_we, sb_any_busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    // Reference model state: "who won last", a bit per register, and the pending write.
    bit        m_last_b;
    bit [31:0] m_sb;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit        last_ga, last_gb;

    always #5 clk = ~clk;

    rf_write_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_any_busy(sb_any_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_sb     = '0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check combinational
    // outputs, then advance the model across the rising edge.
    task automatic cycle(input bit r,
                         input bit av, input bit [4:0] ard, input bit [31:0] adat,
                         input bit bv, input bit [4:0] brd, input bit [31:0] bdat,
                         input bit iv, input bit [4:0] ird,
                         input bit [4:0] r1, input bit [4:0] r2);
        bit        ga, gb;
        bit [31:0] n_sb;
        bit [4:0]  t_rd;
        bit [31:0] t_dat;
        @(negedge clk);
        check("rf_we", rf_we, 32'(m_we));
        check("rf_waddr", rf_waddr, 32'(m_waddr));
        check("rf_wdata", rf_wdata, m_wdata);
        check("sb_any_busy", sb_any_busy, 32'(m_sb[31:1] != 0));
        rst = r; a_valid = av; a_rd = ard; a_data = adat;
        b_valid = bv; b_rd = brd; b_data = bdat;
        iss_valid = iv; iss_rd = ird; rs1_addr = r1; rs2_addr = r2;
        #1;
        if (r)             begin ga = 0;         gb = 0;         end
        else if (av && bv) begin ga = m_last_b;  gb = !m_last_b; end
        else               begin ga = av;        gb = bv;        end
        check("a_ready", a_ready, 32'(ga));
        check("b_ready", b_ready, 32'(gb));
        check("rs1_busy", rs1_busy, 32'(r1 != 0 && m_sb[r1]));
        check("rs2_busy", rs2_busy, 32'(r2 != 0 && m_sb[r2]));
        last_ga = ga; last_gb = gb;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            n_sb = m_sb;
            if (m_we) n_sb[m_waddr] = 1'b0;
            if (iv && ird != 0) n_sb[ird] = 1'b1;
            m_sb = n_sb;
            t_rd  = gb ? brd : ard;
            t_dat = gb ? bdat : adat;
            m_we = (ga || gb) && t_rd != 0;
            if (ga || gb) m_last_b = gb;
            if (m_we) begin
                m_waddr = t_rd;
                m_wdata = t_dat;
            end
        end
    endtask

    task automatic idle(input bit [4:0] r1, input bit [4:0] r2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        bit        pa, pb;
        bit        av, bv;
        bit [4:0]  ard, brd;
        bit [31:0] adat, bdat;

        rst = 1'b1; a_valid = 0; b_valid = 0; iss_valid = 0;
        a_rd = 0; b_rd = 0; iss_rd = 0; a_data = 0; b_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state is checked by the first cycle's registered comparisons.
        cycle(1, 1, 6, 32'h1234, 1, 7, 32'h5678, 1, 8, 8, 6);

        // Single A write.
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("single_we", rf_we, 1);
        check("single_addr", rf_waddr, 5);
        check("single_data", rf_wdata, 32'hDEADBEEF);

        // Contention after reset: A, then B, then A again.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        #1; check("rr1_addr", rf_waddr, 3); check("rr1_data", rf_wdata, 32'h11);
        cycle(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        #1; check("rr2_addr", rf_waddr, 4); check("rr2_data", rf_wdata, 32'h22);
        cycle(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        #1; check("rr3_addr", rf_waddr, 3);

        // Scoreboard: busy held through the write cycle, clear afterwards.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 0, 1, 7, 32'hAA, 0, 0, 7, 0);
        #1; check("sb_busy_in_we", rs1_busy, 1); check("sb_we7", rf_we, 1);
        idle(7, 0);
        #1; check("sb_clear_after", rs1_busy, 0);

        // Set/clear collision on register 9: set wins.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        cycle(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 9);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        #1; check("collide_busy", rs2_busy, 1);

        // x0: accepted, no write, earlier address/data kept; x0 never busy.
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 9);
        #1;
        check("x0_we", rf_we, 0);
        check("x0_addr_kept", rf_waddr, 9);
        check("x0_data_kept", rf_wdata, 32'h99);
        check("x0_busy", rs1_busy, 0);

        // Reset after a transfer discards the pending write.
        cycle(0, 1, 2, 32'h2222, 0, 0, 0, 1, 12, 0, 0);
        cycle(1, 1, 2, 32'h2222, 0, 0, 0, 1, 13, 0, 0);
        #1;
        check("rst_we", rf_we, 0);
        check("rst_addr", rf_waddr, 0);
        check("rst_data", rf_wdata, 0);
        check("rst_any", sb_any_busy, 0);

        // Randomized traffic; a requester that lost arbitration holds its request.
        pa = 0; pb = 0; av = 0; bv = 0; ard = 0; brd = 0; adat = 0; bdat = 0;
        for (int i = 0; i < 2000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            if (!pa) begin
                av = $urandom_range(0, 1); ard = 5'($urandom_range(0, 31)); adat = $urandom;
            end
            if (!pb) begin
                bv = $urandom_range(0, 1); brd = 5'($urandom_range(0, 31)); bdat = $urandom;
            end
            cycle(r, av, ard, adat, bv, brd, bdat,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            pa = av && !last_ga;
            pb = bv && !last_gb;
        end
        idle(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
